regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised integer register file (x0 hardwired to zero) with NREAD asynchronous read ports,
//   one synchronous write port, optional write-to-read bypass and a per-register busy scoreboard.
//   Sits between decode (read operands / mark destination busy on issue) and writeback (write
//   result / clear busy), so the pipeline control can detect RAW hazards without extra logic.
// PARAMETERS
//   XLEN    32  data width of each register
//   NREGS   32  number of registers; power of 2, >= 2; register 0 is hardwired zero
//   NREAD   2   number of read ports, >= 1
//   BYPASS  1   1: same-cycle writeback data is forwarded to matching read ports; 0: no forwarding
//   (local) AW = $clog2(NREGS), CW = $clog2(NREGS)+1
// PORTS
//   clk       in   1           clock, all state updates on posedge
//   rst       in   1           asynchronous, active-high reset
//   ra        in   NREAD*AW    read addresses, port i at ra[i*AW +: AW]
//   rd        out  NREAD*XLEN  read data, port i at rd[i*XLEN +: XLEN]
//   rbusy     out  NREAD       1: register addressed by port i has a pending write
//   wen       in   1           writeback enable
//   wa        in   AW          writeback address
//   wd        in   XLEN        writeback data
//   iss_en    in   1           issue: mark iss_rd busy
//   iss_rd    in   AW          destination register of issued instruction
//   busy_cnt  out  CW          number of registers currently busy
// BEHAVIOUR
//   Reset (async, while rst=1): all registers <= 0, all busy bits <= 0, busy_cnt <= 0.
//     rd/rbusy are combinational, so they read 0 during and after reset. A reset
//     mid-operation discards every pending write and busy mark immediately.
//   Register 0: writes ignored, issue ignored, rd=0 and rbusy=0 for address 0 on every port.
//   Read: combinational, zero latency. rd[i]=rf[ra[i]], rbusy[i]=busy[ra[i]].
//     Bypass (BYPASS=1, wen=1, wa==ra[i], wa!=0): rd[i]=wd and rbusy[i]=0 in that cycle,
//     unless iss_en=1 and iss_rd==ra[i], in which case rbusy[i]=1 (data still forwarded).
//     BYPASS=0: rd[i]/rbusy[i] reflect stored state only; the write is visible next cycle.
//   Write: posedge with wen=1 and wa!=0 -> rf[wa]<=wd, busy[wa]<=0.
//     Writing a non-busy register is legal: data updated, busy_cnt unchanged.
//   Issue: posedge with iss_en=1 and iss_rd!=0 -> busy[iss_rd]<=1.
//     Issuing to an already-busy register (WAW) is legal: stays busy, busy_cnt unchanged.
//   Simultaneous write and issue, same register: data written AND busy stays/becomes 1
//     (new producer wins). Different registers: both take effect independently.
//   busy_cnt: registered, updated incrementally each posedge:
//     +1 if issue sets a previously clear bit; -1 if write clears a previously set bit and the
//     same edge does not re-set it; net of both. Never exceeds NREGS-1 and never underflows.
//     Invariant: busy_cnt == popcount(busy) at all times.
//   Multiple read ports addressing the same register return identical rd/rbusy.
// TESTING
//   1 Reset, then read all 32 addrs on both ports -> rd=0, rbusy=0, busy_cnt=0.
//   2 wen=1 wa=5 wd=32'hDEAD_BEEF, ra0=5 (BYPASS=1) -> rd0=DEADBEEF same cycle; BYPASS=0 ->
//     old value (0) same cycle, DEADBEEF next cycle.
//   3 wen=1 wa=0 wd=32'hFFFF_FFFF, iss_en=1 iss_rd=0 -> ra=0 reads 0, rbusy=0, busy_cnt=0.
//   4 issue x3, x7, x3 on 3 edges -> busy_cnt 1,2,2; write x3 -> busy_cnt=1, rbusy(x3)=0.
//   5 same edge: wen=1 wa=9 wd=32'h1234 and iss_en=1 iss_rd=9 (x9 busy before) -> rf[9]=32'h1234,
//     busy[9]=1, busy_cnt unchanged; ra=9 with BYPASS=1 that cycle -> rd=1234, rbusy=1.
//   6 issue x1..x31 (busy_cnt=31), assert rst between edges -> busy_cnt, rbusy and rd go 0
//     without a clock edge; random issue/write run checks busy_cnt==popcount(busy) every cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with x0 hardwired to zero, NREAD combinational read ports, one write port,
// optional write-to-read bypass, and a per-register busy scoreboard with a running busy count.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  wen,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_rd,
    output logic [CW-1:0]         busy_cnt
);

    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             wr_ok;
    logic             iss_ok;
    logic             set_new;
    logic             clr_old;

    // Register 0 is never written or marked busy, so it reads zero without a special read path.
    assign wr_ok  = wen && (wa != '0);
    assign iss_ok = iss_en && (iss_rd != '0);

    // A write clearing a busy bit does not count when the same edge re-issues that register.
    assign set_new = iss_ok && !busy[iss_rd];
    assign clr_old = wr_ok && busy[wa] && !(iss_ok && (iss_rd == wa));

    always_comb begin
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[wa] = 1'b0;
        if (iss_ok)
            busy_nxt[iss_rd] = 1'b1;
    end

    always_comb begin
        cnt_nxt = busy_cnt;
        if (set_new && !clr_old)
            cnt_nxt = busy_cnt + CW'(1);
        else if (clr_old && !set_new)
            cnt_nxt = busy_cnt - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++)
                rf[k] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok)
                rf[wa] <= wd;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_read
        logic [AW-1:0] a;
        logic          hit;

        assign a   = ra[g*AW +: AW];
        assign hit = (BYPASS != 0) && wr_ok && (wa == a);

        // On a bypass hit the port stays busy only if the same edge issues a new producer.
        assign rd[g*XLEN +: XLEN] = hit ? wd : rf[a];
        assign rbusy[g]           = hit ? (iss_en && (iss_rd == a)) : busy[a];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   ra0, ra1;
    logic [2*AW-1:0] ra;
    logic            wen;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;

    logic [2*XLEN-1:0] rd_b, rd_n;
    logic [1:0]        rbusy_b, rbusy_n;
    logic [CW-1:0]     cnt_b, cnt_n;

    int checks   = 0;
    int failures = 0;

    assign ra = {ra1, ra0};

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .wen(wen), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_rd(iss_rd), .busy_cnt(cnt_b)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
        .wen(wen), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_rd(iss_rd), .busy_cnt(cnt_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        wen = 1'b0; wa = '0; wd = '0; iss_en = 1'b0; iss_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); ra0 = '0; ra1 = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int a = 0; a < 32; a++) begin
            ra0 = AW'(a); ra1 = AW'(31 - a);
            #1;
            checks++;
            if (rd_b !== '0 || rd_n !== '0 || rbusy_b !== 2'b00 || rbusy_n !== 2'b00) begin
                failures++;
                $display("FAIL reset_read addr=%0d got rd_b=%h rd_n=%h rbusy_b=%b rbusy_n=%b exp all 0",
                         a, rd_b, rd_n, rbusy_b, rbusy_n);
            end
        end
        checks++;
        if (cnt_b !== 6'd0 || cnt_n !== 6'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0", cnt_b, cnt_n);
        end
    endtask

    task automatic test_bypass();
        wen = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra0 = 5'd5; ra1 = 5'd5;
        #1;
        checks++;
        if (rd_b[31:0] !== 32'hDEAD_BEEF || rd_b[63:32] !== 32'hDEAD_BEEF || rbusy_b !== 2'b00) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h rbusy=%b exp=deadbeef/deadbeef rbusy=00", rd_b, rbusy_b);
        end
        checks++;
        if (rd_n[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL nobypass_same_cycle got=%h exp=00000000", rd_n[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_n[31:0] !== 32'hDEAD_BEEF || rd_b[31:0] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_next_cycle got=%h/%h exp=deadbeef", rd_n[31:0], rd_b[31:0]);
        end
    endtask

    task automatic test_x0();
        wen = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; iss_en = 1'b1; iss_rd = 5'd0;
        ra0 = 5'd0; ra1 = 5'd0;
        #1;
        checks++;
        if (rd_b !== '0 || rbusy_b !== 2'b00) begin
            failures++;
            $display("FAIL x0_comb got rd=%h rbusy=%b exp 0/00", rd_b, rbusy_b);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_b !== '0 || rd_n !== '0 || rbusy_b !== 2'b00 || cnt_b !== 6'd0 || cnt_n !== 6'd0) begin
            failures++;
            $display("FAIL x0_after got rd=%h rbusy=%b cnt=%0d exp 0/00/0", rd_b, rbusy_b, cnt_b);
        end
    endtask

    task automatic test_issue();
        logic [AW-1:0] regs [3];
        int            exp_cnt [3];
        regs[0] = 5'd3; regs[1] = 5'd7; regs[2] = 5'd3;
        exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 2;
        for (int i = 0; i < 3; i++) begin
            iss_en = 1'b1; iss_rd = regs[i];
            tick();
            checks++;
            if (cnt_b !== CW'(exp_cnt[i]) || cnt_n !== CW'(exp_cnt[i])) begin
                failures++;
                $display("FAIL issue_cnt step=%0d got=%0d/%0d exp=%0d", i, cnt_b, cnt_n, exp_cnt[i]);
            end
        end
        idle();
        ra0 = 5'd3; ra1 = 5'd7;
        #1;
        checks++;
        if (rbusy_b !== 2'b11) begin
            failures++;
            $display("FAIL issue_rbusy got=%b exp=11", rbusy_b);
        end
        wen = 1'b1; wa = 5'd3; wd = 32'h0000_0033;
        tick();
        idle();
        #1;
        checks++;
        if (cnt_b !== 6'd1 || rbusy_b !== 2'b10 || rbusy_n !== 2'b10 || rd_b[31:0] !== 32'h33) begin
            failures++;
            $display("FAIL write_clears got cnt=%0d rbusy=%b rd0=%h exp 1/10/00000033", cnt_b, rbusy_b, rd_b[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        iss_en = 1'b1; iss_rd = 5'd9;
        tick();
        checks++;
        if (cnt_b !== 6'd2) begin
            failures++;
            $display("FAIL pre_simul_cnt got=%0d exp=2", cnt_b);
        end
        wen = 1'b1; wa = 5'd9; wd = 32'h1234; iss_en = 1'b1; iss_rd = 5'd9;
        ra0 = 5'd9; ra1 = 5'd9;
        #1;
        checks++;
        if (rd_b[31:0] !== 32'h1234 || rbusy_b !== 2'b11 || rd_n[31:0] !== 32'h0 || rbusy_n !== 2'b11) begin
            failures++;
            $display("FAIL simul_comb got rd_b=%h rbusy_b=%b rd_n=%h rbusy_n=%b exp 1234/11/0/11",
                     rd_b[31:0], rbusy_b, rd_n[31:0], rbusy_n);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_n[31:0] !== 32'h1234 || rbusy_n !== 2'b11 || cnt_b !== 6'd2 || cnt_n !== 6'd2) begin
            failures++;
            $display("FAIL simul_after got rd=%h rbusy=%b cnt=%0d exp 1234/11/2", rd_n[31:0], rbusy_n, cnt_b);
        end
        // Different registers on the same edge: x7 clears, x11 sets.
        wen = 1'b1; wa = 5'd7; wd = 32'h77; iss_en = 1'b1; iss_rd = 5'd11;
        tick();
        idle();
        ra0 = 5'd7; ra1 = 5'd11;
        #1;
        checks++;
        if (cnt_b !== 6'd2 || rbusy_b !== 2'b10 || rd_b[31:0] !== 32'h77) begin
            failures++;
            $display("FAIL diff_regs got cnt=%0d rbusy=%b rd0=%h exp 2/10/00000077", cnt_b, rbusy_b, rd_b[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r < 32; r++) begin
            iss_en = 1'b1; iss_rd = AW'(r);
            tick();
        end
        idle();
        ra0 = 5'd9; ra1 = 5'd31;
        #1;
        checks++;
        if (cnt_b !== 6'd31 || rbusy_b !== 2'b11 || rd_b[31:0] !== 32'h1234) begin
            failures++;
            $display("FAIL all_busy got cnt=%0d rbusy=%b rd0=%h exp 31/11/00001234", cnt_b, rbusy_b, rd_b[31:0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cnt_b !== 6'd0 || cnt_n !== 6'd0 || rbusy_b !== 2'b00 || rd_b !== '0 || rd_n !== '0) begin
            failures++;
            $display("FAIL async_reset got cnt=%0d rbusy=%b rd=%h exp 0/00/0", cnt_b, rbusy_b, rd_b);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [XLEN-1:0] mrf [32];
        logic [31:0]     mbusy;
        logic [XLEN-1:0] ed;
        logic            eb;
        logic [AW-1:0]   a;
        int              pop;
        for (int k = 0; k < 32; k++) mrf[k] = '0;
        mbusy = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            wen = 1'($urandom_range(0, 1)); wa = AW'($urandom_range(0, 7));
            wd = $urandom; iss_en = 1'($urandom_range(0, 1)); iss_rd = AW'($urandom_range(0, 7));
            ra0 = AW'($urandom_range(0, 7)); ra1 = AW'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < 2; p++) begin
                a = (p == 0) ? ra0 : ra1;
                if (wen && wa == a && a != 0) begin
                    ed = wd; eb = iss_en && (iss_rd == a);
                end else begin
                    ed = mrf[a]; eb = mbusy[a];
                end
                checks++;
                if (rd_b[p*XLEN +: XLEN] !== ed || rbusy_b[p] !== eb ||
                    rd_n[p*XLEN +: XLEN] !== mrf[a] || rbusy_n[p] !== mbusy[a]) begin
                    failures++;
                    $display("FAIL rand_read cyc=%0d port=%0d addr=%0d got b=%h/%b n=%h/%b exp b=%h/%b n=%h/%b",
                             cyc, p, a, rd_b[p*XLEN +: XLEN], rbusy_b[p], rd_n[p*XLEN +: XLEN], rbusy_n[p],
                             ed, eb, mrf[a], mbusy[a]);
                end
            end
            if (wen && wa != 0) begin
                mrf[wa] = wd; mbusy[wa] = 1'b0;
            end
            if (iss_en && iss_rd != 0) mbusy[iss_rd] = 1'b1;
            tick();
            pop = 0;
            for (int k = 0; k < 32; k++) pop += int'(mbusy[k]);
            checks++;
            if (cnt_b !== CW'(pop) || cnt_n !== CW'(pop)) begin
                failures++;
                $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d", cyc, cnt_b, cnt_n, pop);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle(); ra0 = '0; ra1 = '0;
        test_reset();
        test_bypass();
        test_x0();
        test_issue();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
